bsg_fifo_1r1w_rr_ctrl: RTL and testbench

//  Controller that runs the 2-entry 1r1w synth memory as a FIFO shared by two producers.
//  - Round-robin arbitration of two valid/ready producers onto the single write port.
//  - Pointer and full/empty tracking.
//  - Drives memory write/read controls; presents the head entry to one valid/yumi consumer.
//  - Memory is external: write is synchronous, read is combinational; no same-address read+write in a cycle.

---
 rtl/bsg_fifo_1r1w_rr_ctrl.sv | 142 ++++++++++++++
 tb/tb_bsg_fifo_1r1w_rr_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_1r1w_rr_ctrl.sv
// Two-producer, one-consumer FIFO controller for an external 1r1w memory
// (synchronous write, combinational read), with round-robin write arbitration.

module bsg_fifo_1r1w_rr_ctrl #(
    parameter int width_p = 30,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v0_i,
    input  logic [width_p-1:0]         data0_i,
    output logic                       ready0_o,
    input  logic                       v1_i,
    input  logic [width_p-1:0]         data1_i,
    output logic                       ready1_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o,
    output logic                       mem_w_v_o,
    output logic [$clog2(els_p)-1:0]   mem_w_addr_o,
    output logic [width_p-1:0]         mem_w_data_o,
    output logic                       mem_r_v_o,
    output logic [$clog2(els_p)-1:0]   mem_r_addr_o,
    input  logic [width_p-1:0]         mem_r_data_i
);

    localparam int lg_lp    = $clog2(els_p);
    localparam int ptr_w_lp = lg_lp + 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = {{(ptr_w_lp-1){1'b0}}, 1'b1};
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = {{(cnt_w_lp-1){1'b0}}, 1'b1};

    // Pointer MSB is the wrap bit; plain increment wraps the index and toggles it.
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                prio_q, prio_d;
    logic                grant0_s, grant1_s, empty_s, full_s, enq_s, deq_s;

    // Arbitration, handshakes and next-state computation.
    always_comb begin
        grant0_s = v0_i & (~v1_i | ~prio_q);
        grant1_s = v1_i & (~v0_i |  prio_q);
        empty_s  = (wptr_q == rptr_q);
        full_s   = (wptr_q[lg_lp-1:0] == rptr_q[lg_lp-1:0]) & (wptr_q[lg_lp] != rptr_q[lg_lp]);
        enq_s    = (grant0_s | grant1_s) & ~full_s;
        deq_s    = yumi_i & ~empty_s;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        prio_d  = prio_q;
        count_d = count_q;

        if (enq_s) begin
            wptr_d = wptr_q + ptr_one_lp;
            // Priority goes to whichever producer was not just served.
            prio_d = grant0_s;
        end else begin
            wptr_d = wptr_q;
        end

        if (deq_s) begin
            rptr_d = rptr_q + ptr_one_lp;
        end else begin
            rptr_d = rptr_q;
        end

        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + cnt_one_lp;
            2'b01:   count_d = count_q - cnt_one_lp;
            default: count_d = count_q;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            prio_q  <= prio_d;
        end
    end

    assign ready0_o     = grant0_s & ~full_s;
    assign ready1_o     = grant1_s & ~full_s;
    assign v_o          = ~empty_s;
    assign data_o       = mem_r_data_i;
    assign count_o      = count_q;
    assign mem_w_v_o    = enq_s;
    assign mem_w_addr_o = wptr_q[lg_lp-1:0];
    assign mem_w_data_o = grant1_s ? data1_i : data0_i;
    assign mem_r_v_o    = ~empty_s;
    assign mem_r_addr_o = rptr_q[lg_lp-1:0];

    bsg_fifo_1r1w_rr_ctrl_chk u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .yumi_i    (yumi_i),
        .v_i       (~empty_s),
        .ready0_i  (ready0_o),
        .ready1_i  (ready1_o)
    );

endmodule

// Protocol checker: illegal consumer yumi and mutually exclusive producer readies.
module bsg_fifo_1r1w_rr_ctrl_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic yumi_i,
    input logic v_i,
    input logic ready0_i,
    input logic ready1_i
);

    logic [7:0] fire_q;

    // Counts illegal yumi events; the controller itself ignores them.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fire_q <= 8'd0;
        end else if (yumi_i) begin
            a_yumi_needs_v: assert (v_i) else fire_q <= fire_q + 8'd1;
        end else begin
            fire_q <= fire_q;
        end
    end

    // At most one producer may be accepted per cycle.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            a_one_ready: assert (!(ready0_i && ready1_i));
        end
    end

endmodule

// File: tb/tb_bsg_fifo_1r1w_rr_ctrl.sv
// Directed self-checking bench for bsg_fifo_1r1w_rr_ctrl with a behavioural 1r1w memory.

module tb_bsg_fifo_1r1w_rr_ctrl;

    logic        clk, reset_n;
    logic        v0, v1, ready0, ready1, v_o, yumi;
    logic [29:0] data0, data1, data_o;
    logic [1:0]  count;
    logic        mem_w_v, mem_r_v;
    logic [0:0]  mem_w_addr, mem_r_addr;
    logic [29:0] mem_w_data, mem_r_data;
    logic [29:0] mem [2];

    int total = 0;
    int bad   = 0;

    bsg_fifo_1r1w_rr_ctrl #(.width_p(30), .els_p(2)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .v0_i         (v0),
        .data0_i      (data0),
        .ready0_o     (ready0),
        .v1_i         (v1),
        .data1_i      (data1),
        .ready1_o     (ready1),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi),
        .count_o      (count),
        .mem_w_v_o    (mem_w_v),
        .mem_w_addr_o (mem_w_addr),
        .mem_w_data_o (mem_w_data),
        .mem_r_v_o    (mem_r_v),
        .mem_r_addr_o (mem_r_addr),
        .mem_r_data_i (mem_r_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_w_v) mem[mem_w_addr] <= mem_w_data;
    end
    assign mem_r_data = mem[mem_r_addr];

    task automatic cyc(input logic a0, input logic [29:0] d0, input logic a1,
                       input logic [29:0] d1, input logic y);
        @(negedge clk);
        v0 = a0; data0 = d0; v1 = a1; data1 = d1; yumi = y;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; yumi = 1'b0;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; v0 = 1'b0; v1 = 1'b0; yumi = 1'b0;
        data0 = 30'h0; data1 = 30'h0;
        mem[0] = 30'h3DEAD; mem[1] = 30'h3BEEF;
        @(negedge clk); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o got=%0b exp=0", v_o); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (mem_r_v !== 1'b0) begin bad++; $display("FAIL reset_mem_r_v got=%0b exp=0", mem_r_v); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_enq;
        cyc(1'b1, 30'h0AA, 1'b0, 30'h0, 1'b0);
        total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%0b exp=1", ready0); end
        total++; if (mem_w_v !== 1'b1 || mem_w_addr !== 1'b0 || mem_w_data !== 30'h0AA) begin
            bad++; $display("FAIL single_wr got=%0b/%0d/%h exp=1/0/0aa", mem_w_v, mem_w_addr, mem_w_data); end
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%0b exp=0", v_o); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b1);
        total++; if (v_o !== 1'b1 || data_o !== 30'h0AA || count !== 2'd1) begin
            bad++; $display("FAIL single_head got=%0b/%h/%0d exp=1/0aa/1", v_o, data_o, count); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        total++; if (v_o !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL single_drained got=%0b/%0d exp=0/0", v_o, count); end
    endtask

    task automatic test_arbitration;
        do_reset();
        cyc(1'b1, 30'h111, 1'b1, 30'h222, 1'b0);
        total++; if (ready0 !== 1'b1 || ready1 !== 1'b0 || mem_w_data !== 30'h111) begin
            bad++; $display("FAIL arb_c0 got=%0b%0b/%h exp=10/111", ready0, ready1, mem_w_data); end
        cyc(1'b1, 30'h111, 1'b1, 30'h222, 1'b0);
        total++; if (ready0 !== 1'b0 || ready1 !== 1'b1 || mem_w_addr !== 1'b1 || mem_w_data !== 30'h222) begin
            bad++; $display("FAIL arb_c1 got=%0b%0b/%0d/%h exp=01/1/222", ready0, ready1, mem_w_addr, mem_w_data); end
        cyc(1'b1, 30'h111, 1'b1, 30'h222, 1'b0);
        total++; if (ready0 !== 1'b0 || ready1 !== 1'b0 || mem_w_v !== 1'b0 || count !== 2'd2) begin
            bad++; $display("FAIL arb_full got=%0b%0b/%0b/%0d exp=00/0/2", ready0, ready1, mem_w_v, count); end
        // Full with a dequeue in the same cycle: no pass-through enqueue.
        cyc(1'b0, 30'h0, 1'b1, 30'h333, 1'b1);
        total++; if (ready1 !== 1'b0 || mem_w_v !== 1'b0 || data_o !== 30'h111) begin
            bad++; $display("FAIL full_yumi got=%0b/%0b/%h exp=0/0/111", ready1, mem_w_v, data_o); end
        cyc(1'b0, 30'h0, 1'b1, 30'h333, 1'b0);
        total++; if (data_o !== 30'h222 || ready1 !== 1'b1 || count !== 2'd1 || mem_w_addr !== 1'b0) begin
            bad++; $display("FAIL full_after got=%h/%0b/%0d/%0d exp=222/1/1/0", data_o, ready1, count, mem_w_addr); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b1);
        total++; if (data_o !== 30'h222 || count !== 2'd2) begin
            bad++; $display("FAIL drain_b got=%h/%0d exp=222/2", data_o, count); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b1);
        total++; if (data_o !== 30'h333 || count !== 2'd1) begin
            bad++; $display("FAIL drain_c got=%h/%0d exp=333/1", data_o, count); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        total++; if (v_o !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL drain_empty got=%0b/%0d exp=0/0", v_o, count); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        cyc(1'b1, 30'h100, 1'b0, 30'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 30'h101 + 30'(i), 1'b0, 30'h0, 1'b1);
            total++; if (data_o !== 30'h100 + 30'(i) || count !== 2'd1 || ready0 !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d got=%h/%0d/%0b exp=%h/1/1", i, data_o, count, ready0, 30'h100 + 30'(i)); end
            total++; if (mem_w_addr !== 1'((i + 1) % 2) || mem_r_addr !== 1'(i % 2)) begin
                bad++; $display("FAIL b2b_addr_%0d got=w%0d/r%0d exp=w%0d/r%0d", i, mem_w_addr, mem_r_addr, (i + 1) % 2, i % 2); end
        end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b1);
        total++; if (data_o !== 30'h106 || count !== 2'd1) begin
            bad++; $display("FAIL b2b_last got=%h/%0d exp=106/1", data_o, count); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        total++; if (v_o !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL b2b_empty got=%0b/%0d exp=0/0", v_o, count); end
    endtask

    task automatic test_illegal_yumi;
        do_reset();
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b1);
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        total++; if (v_o !== 1'b0 || count !== 2'd0 || mem_r_addr !== 1'b0) begin
            bad++; $display("FAIL illegal_state got=%0b/%0d/%0d exp=0/0/0", v_o, count, mem_r_addr); end
        total++; if (dut.u_chk.fire_q !== 8'd1) begin
            bad++; $display("FAIL illegal_assert got=%0d exp=1", dut.u_chk.fire_q); end
        cyc(1'b0, 30'h0, 1'b1, 30'h055, 1'b0);
        total++; if (ready1 !== 1'b1 || mem_w_addr !== 1'b0) begin
            bad++; $display("FAIL illegal_wptr got=%0b/%0d exp=1/0", ready1, mem_w_addr); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        total++; if (v_o !== 1'b1 || data_o !== 30'h055 || count !== 2'd1) begin
            bad++; $display("FAIL illegal_after got=%0b/%h/%0d exp=1/055/1", v_o, data_o, count); end
    endtask

    task automatic test_async_reset;
        do_reset();
        cyc(1'b1, 30'h0A1, 1'b1, 30'h0B2, 1'b0);
        cyc(1'b1, 30'h0A1, 1'b1, 30'h0B2, 1'b0);
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
        total++; if (count !== 2'd2) begin bad++; $display("FAIL ar_full got=%0d exp=2", count); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (v_o !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL ar_immediate got=%0b/%0d exp=0/0", v_o, count); end
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 30'h0C3, 1'b1, 30'h0D4, 1'b0);
        total++; if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            bad++; $display("FAIL ar_prio got=%0b%0b exp=10", ready0, ready1); end
        cyc(1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_enq();
        test_arbitration();
        test_back_to_back();
        test_illegal_yumi();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
